// File: rtl/mmu_req_sched_pkg.sv
// ---------------------------------------------------------------------------
// mmu_req_sched_pkg
//
// Shared definitions for the MMU request scheduler and its size normaliser:
//   - default widths of the request/response path (id, page index, page
//     count, FIFO pointer),
//   - page-count size-class encodings and the largest legal page count,
//   - scheduler state encoding.
// ---------------------------------------------------------------------------
package mmu_req_sched_pkg;

    // Default datapath widths shared with the FIFOs and the engine.
    localparam int REQ_ID_WIDTH        = 13;
    localparam int ALL_PAGE_IDX_WIDTH  = 15;
    localparam int REQ_SIZE_TYPE_WIDTH = 4;
    localparam int FIFO_PTR_WIDTH      = 4;

    // Size classes: a request is rounded up to 1, 2, 4 or 8 pages.
    localparam logic [1:0] SZ_1 = 2'd0;
    localparam logic [1:0] SZ_2 = 2'd1;
    localparam logic [1:0] SZ_4 = 2'd2;
    localparam logic [1:0] SZ_8 = 2'd3;

    // Largest page count a single request may ask for.
    localparam int MAX_PAGE_COUNT = 8;

    // Scheduler state machine encoding.
    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_LOAD  = 2'd1,
        SCHED_ISSUE = 2'd2
    } sched_state_e;

endpackage : mmu_req_sched_pkg

// File: rtl/mmu_size_norm.sv
// ---------------------------------------------------------------------------
// mmu_size_norm
//
// Combinational page-count normaliser. Maps a raw page count onto a size
// class (1/2/4/8 pages) and flags counts that cannot be served. Shared with
// the allocation engine so both sides agree on the mapping.
//
// Ports:
//   page_count  in  CNT_W  raw page count from the request
//   size_err    out 1      count was 0 or above MAX_PAGE_COUNT
//   size_class  out 2      SZ_1/SZ_2/SZ_4/SZ_8; SZ_1 whenever size_err is set
// ---------------------------------------------------------------------------
module mmu_size_norm
    import mmu_req_sched_pkg::*;
#(
    parameter int CNT_W = REQ_SIZE_TYPE_WIDTH
) (
    input  logic [CNT_W-1:0] page_count,
    output logic             size_err,
    output logic [1:0]       size_class
);

    // Zero-extend so the range compare is safe for any CNT_W.
    logic [31:0] count_ext;

    assign count_ext = 32'(page_count);

    always_comb begin
        size_err   = 1'b0;
        size_class = SZ_1;
        if ((count_ext == 32'd0) || (count_ext > 32'(MAX_PAGE_COUNT))) begin
            size_err = 1'b1;
        end else if (count_ext == 32'd1) begin
            size_class = SZ_1;
        end else if (count_ext == 32'd2) begin
            size_class = SZ_2;
        end else if (count_ext <= 32'd4) begin
            size_class = SZ_4;
        end else begin
            size_class = SZ_8;
        end
    end

endmodule : mmu_size_norm

// File: rtl/mmu_req_sched.sv
// ---------------------------------------------------------------------------
// mmu_req_sched
//
// Request scheduler between the alloc/free request FIFOs and the MMU
// allocation engine. Round-robin arbitrates between the two queues, pops one
// request, normalises its page count and presents a single command to the
// engine over valid/ready. A grant is only made when the target response FIFO
// has room for every command already issued plus this one.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   sched_en                    0 blocks new grants (current command finishes)
//   alloc_fifo_empty/_req_*     alloc request FIFO status and read data
//   alloc_req_pop               alloc FIFO read enable (one cycle per grant)
//   free_fifo_empty/_req_*      free request FIFO status and read data
//   free_req_pop                free FIFO read enable (one cycle per grant)
//   *_rsp_free_count            free slots in each response FIFO
//   *_rsp_write_en              engine wrote one response to that FIFO
//   cmd_valid/cmd_ready         command handshake to the engine
//   cmd_is_free, cmd_id,
//   cmd_page_idx,
//   cmd_size_class, cmd_size_err command payload
//   sched_busy                  not idle, or commands still unanswered
// ---------------------------------------------------------------------------
module mmu_req_sched
    import mmu_req_sched_pkg::*;
#(
    parameter int ID_W  = REQ_ID_WIDTH,
    parameter int IDX_W = ALL_PAGE_IDX_WIDTH,
    parameter int CNT_W = REQ_SIZE_TYPE_WIDTH,
    parameter int PTR_W = FIFO_PTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sched_en,

    input  logic             alloc_fifo_empty,
    input  logic [ID_W-1:0]  alloc_req_id,
    input  logic [CNT_W-1:0] alloc_req_page_count,
    output logic             alloc_req_pop,

    input  logic             free_fifo_empty,
    input  logic [ID_W-1:0]  free_req_id,
    input  logic [IDX_W-1:0] free_req_page_idx,
    input  logic [CNT_W-1:0] free_req_page_count,
    output logic             free_req_pop,

    input  logic [PTR_W:0]   alloc_rsp_free_count,
    input  logic [PTR_W:0]   free_rsp_free_count,
    input  logic             alloc_rsp_write_en,
    input  logic             free_rsp_write_en,

    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_is_free,
    output logic [ID_W-1:0]  cmd_id,
    output logic [IDX_W-1:0] cmd_page_idx,
    output logic [1:0]       cmd_size_class,
    output logic             cmd_size_err,

    output logic             sched_busy
);

    localparam int CW = PTR_W + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    sched_state_e     state_q,          state_d;
    logic             last_grant_q,     last_grant_d;   // 1 = free queue
    logic             gnt_free_q,       gnt_free_d;
    logic             cmd_is_free_q,    cmd_is_free_d;
    logic [ID_W-1:0]  cmd_id_q,         cmd_id_d;
    logic [IDX_W-1:0] cmd_page_idx_q,   cmd_page_idx_d;
    logic [1:0]       cmd_size_class_q, cmd_size_class_d;
    logic             cmd_size_err_q,   cmd_size_err_d;
    logic [CW-1:0]    alloc_out_q,      alloc_out_d;
    logic [CW-1:0]    free_out_q,       free_out_d;

    logic             alloc_ok;
    logic             free_ok;
    logic             grant_alloc;
    logic             grant_free;

    logic [CNT_W-1:0] sel_count;
    logic             norm_err;
    logic [1:0]       norm_class;

    // -----------------------------------------------------------------------
    // Size normalisation of whichever queue was granted. The FIFO read data
    // is valid in LOAD, one cycle after the pop.
    // -----------------------------------------------------------------------
    assign sel_count = gnt_free_q ? free_req_page_count : alloc_req_page_count;

    mmu_size_norm #(
        .CNT_W (CNT_W)
    ) u_size_norm (
        .page_count (sel_count),
        .size_err   (norm_err),
        .size_class (norm_class)
    );

    // -----------------------------------------------------------------------
    // Eligibility: a queue may be granted only while its response FIFO has
    // room beyond the commands already outstanding on it.
    // -----------------------------------------------------------------------
    assign alloc_ok = sched_en & ~alloc_fifo_empty & (alloc_out_q < alloc_rsp_free_count);
    assign free_ok  = sched_en & ~free_fifo_empty  & (free_out_q  < free_rsp_free_count);

    // Saturating up/down counter step. Simultaneous grant and response cancel;
    // a step past either end is a protocol error and is simply held.
    function automatic logic [CW-1:0] out_next(
        input logic [CW-1:0] cur,
        input logic          inc,
        input logic          dec
    );
        out_next = cur;
        if (inc && !dec && (cur != CNT_MAX)) begin
            out_next = cur + CW'(1);
        end else if (dec && !inc && (cur != '0)) begin
            out_next = cur - CW'(1);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Next-state, arbitration and command capture
    // -----------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        gnt_free_d       = gnt_free_q;
        cmd_is_free_d    = cmd_is_free_q;
        cmd_id_d         = cmd_id_q;
        cmd_page_idx_d   = cmd_page_idx_q;
        cmd_size_class_d = cmd_size_class_q;
        cmd_size_err_d   = cmd_size_err_q;
        grant_alloc      = 1'b0;
        grant_free       = 1'b0;

        case (state_q)
            SCHED_IDLE: begin
                // On a tie, serve the queue that was not served last.
                if (alloc_ok && (!free_ok || last_grant_q)) begin
                    grant_alloc = 1'b1;
                end else if (free_ok) begin
                    grant_free = 1'b1;
                end

                if (grant_alloc || grant_free) begin
                    gnt_free_d   = grant_free;
                    last_grant_d = grant_free;
                    state_d      = SCHED_LOAD;
                end
            end

            SCHED_LOAD: begin
                cmd_is_free_d    = gnt_free_q;
                cmd_id_d         = gnt_free_q ? free_req_id : alloc_req_id;
                cmd_page_idx_d   = gnt_free_q ? free_req_page_idx : '0;
                cmd_size_class_d = norm_class;
                cmd_size_err_d   = norm_err;
                state_d          = SCHED_ISSUE;
            end

            SCHED_ISSUE: begin
                if (cmd_ready) begin
                    state_d = SCHED_IDLE;
                end
            end

            default: begin
                state_d = SCHED_IDLE;
            end
        endcase

        alloc_out_d = out_next(alloc_out_q, grant_alloc, alloc_rsp_write_en);
        free_out_d  = out_next(free_out_q,  grant_free,  free_rsp_write_en);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= SCHED_IDLE;
            last_grant_q     <= 1'b1;     // first tie after reset goes to alloc
            gnt_free_q       <= 1'b0;
            cmd_is_free_q    <= 1'b0;
            cmd_id_q         <= '0;
            cmd_page_idx_q   <= '0;
            cmd_size_class_q <= '0;
            cmd_size_err_q   <= 1'b0;
            alloc_out_q      <= '0;
            free_out_q       <= '0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            gnt_free_q       <= gnt_free_d;
            cmd_is_free_q    <= cmd_is_free_d;
            cmd_id_q         <= cmd_id_d;
            cmd_page_idx_q   <= cmd_page_idx_d;
            cmd_size_class_q <= cmd_size_class_d;
            cmd_size_err_q   <= cmd_size_err_d;
            alloc_out_q      <= alloc_out_d;
            free_out_q       <= free_out_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Pops are Mealy so the FIFO sees its read enable in the grant
    // cycle and presents data in LOAD.
    // -----------------------------------------------------------------------
    assign alloc_req_pop  = grant_alloc;
    assign free_req_pop   = grant_free;

    assign cmd_valid      = (state_q == SCHED_ISSUE);
    assign cmd_is_free    = cmd_is_free_q;
    assign cmd_id         = cmd_id_q;
    assign cmd_page_idx   = cmd_page_idx_q;
    assign cmd_size_class = cmd_size_class_q;
    assign cmd_size_err   = cmd_size_err_q;

    assign sched_busy     = (state_q != SCHED_IDLE) | (|alloc_out_q) | (|free_out_q);

endmodule : mmu_req_sched

// File: doc/mmu_req_sched.md
# mmu_req_sched

Request scheduler between the alloc/free request FIFOs and the MMU allocation engine. It arbitrates round-robin between the two request queues and pops one request at a time. It normalises the page count into a size class and presents a single command to the engine over a valid/ready handshake. Grants are credit-limited, so that every issued command is guaranteed space in its response FIFO.

## Interface
Parameters:
- `ID_W`, default `REQ_ID_WIDTH` (13): request id width.
- `IDX_W`, default `ALL_PAGE_IDX_WIDTH` (15): page index width.
- `CNT_W`, default `REQ_SIZE_TYPE_WIDTH` (4): page count width.
- `PTR_W`, default `FIFO_PTR_WIDTH`: FIFO pointer width. The free-count width is `PTR_W+1`.

Ports:
- `clk`  in  1  clock; the only clock in the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sched_en`  in  1  level; 0 blocks new grants.
- `alloc_fifo_empty`  in  1  alloc request FIFO empty.
- `alloc_req_id`  in  ID_W  alloc FIFO read data, valid the cycle after pop.
- `alloc_req_page_count`  in  CNT_W  alloc FIFO read data, valid the cycle after pop.
- `alloc_req_pop`  out  1  alloc FIFO read enable.
- `free_fifo_empty`  in  1  free request FIFO empty.
- `free_req_id`  in  ID_W  free FIFO read data, valid the cycle after pop.
- `free_req_page_idx`  in  IDX_W  free FIFO read data, valid the cycle after pop.
- `free_req_page_count`  in  CNT_W  free FIFO read data, valid the cycle after pop.
- `free_req_pop`  out  1  free FIFO read enable.
- `alloc_rsp_free_count`  in  PTR_W+1  free slots in the alloc response FIFO.
- `free_rsp_free_count`  in  PTR_W+1  free slots in the free response FIFO.
- `alloc_rsp_write_en`  in  1  engine wrote one alloc response.
- `free_rsp_write_en`  in  1  engine wrote one free response.
- `cmd_valid`  out  1  command valid.
- `cmd_ready`  in  1  engine accepts the command.
- `cmd_is_free`  out  1  1 = free command, 0 = alloc command.
- `cmd_id`  out  ID_W  request id.
- `cmd_page_idx`  out  IDX_W  page index; 0 for alloc commands.
- `cmd_size_class`  out  2  0/1/2/3 = 1/2/4/8 pages.
- `cmd_size_err`  out  1  page count was 0 or greater than 8.
- `sched_busy`  out  1  state is not IDLE, or any outstanding counter is nonzero.

## Operation
- The state machine has three states: IDLE, LOAD, ISSUE. Reset puts it in IDLE.
- Eligibility:
  - `alloc_ok` = `sched_en` & ~`alloc_fifo_empty` & (`alloc_out` < `alloc_rsp_free_count`).
  - `free_ok` is defined the same way for the free queue, using `free_out` and `free_rsp_free_count`.
- Grant, in IDLE only:
  - If exactly one queue is ok, grant that queue.
  - If both are ok, grant the queue opposite to `last_grant`.
  - Pop is combinational (Mealy): the granted queue's pop is high for exactly one cycle.
  - On a grant, register `gnt_free`, update `last_grant`, increment that queue's outstanding counter, and go to LOAD.
- LOAD:
  - Capture the granted FIFO's read data.
  - Compute the size class: count 1→0, 2→1, 3..4→2, 5..8→3.
  - Count 0 or count > 8 → `cmd_size_err`=1 and `cmd_size_class`=0.
  - Alloc commands carry `cmd_page_idx`=0.
  - Go to ISSUE.
- ISSUE:
  - `cmd_valid`=1. All cmd fields stay stable until `cmd_ready`.
  - On `cmd_ready`, go to IDLE.
  - Responses never pass through this block; size errors go to the engine, which generates the fail response.
- Outstanding counters `alloc_out` and `free_out`:
  - Width PTR_W+1.
  - +1 on grant of that queue; -1 on that queue's `*_rsp_write_en`.
  - Grant and write_en in the same cycle leaves the counter unchanged.
  - A decrement at 0 or an increment at maximum is a protocol error. The counter saturates and must never wrap.
- `sched_en` deasserted mid-operation: the current command completes through ISSUE, and no new grant is made.

## Timing
- Reset values: `alloc_req_pop`=0, `free_req_pop`=0, `cmd_valid`=0, all cmd fields 0, `sched_busy`=0, `last_grant`=free (so the first tie goes to alloc), both counters 0.
- Latency: eligible in cycle t (IDLE) → pop in t → capture at the end of t+1 → `cmd_valid` from t+2.
- Back-to-back throughput: if `cmd_ready` is high in t+2, the next grant can occur in t+3. Peak rate is one command per 3 cycles.
- The block never pops a queue whose FIFO is empty, and never has two pops high in one cycle.
- Credit rule: the number of issued, unanswered commands per queue never exceeds that queue's response FIFO free count, so the engine never sees a full response FIFO.
- `cmd_valid`, once asserted, stays high until `cmd_ready`, with no field changes. `cmd_ready` is sampled only in ISSUE.
- `rst_n` asserted mid-operation: immediate return to IDLE, all outputs to their reset values, counters cleared. A popped but unissued request is lost; the system-level reset clears the FIFOs as well.

## Structure
- Add to `mmu_param.vh`:
  - Size-class encodings SZ_1/SZ_2/SZ_4/SZ_8.
  - `MAX_PAGE_COUNT` (8).
  - Scheduler state encodings.
- One natural sub-module: `mmu_size_norm`, the combinational page_count → {size_err, size_class} mapping. The engine reuses it for its own checks.
- The arbiter, state machine and counters stay inline in `mmu_req_sched`.

## Test plan
- Single alloc:
  - Stimulus: id=5, count=3, `cmd_ready` tied to 1.
  - Response: pop at t, `cmd_valid` at t+2 with is_free=0, id=5, class=2, err=0; `alloc_out`=1 until `alloc_rsp_write_en`, then 0.
- Both queues always non-empty, `cmd_ready`=1:
  - Response: grants alternate alloc, free, alloc, ..., with the first grant to alloc after reset.
- Credit limit:
  - Stimulus: `alloc_rsp_free_count`=2, alloc queue full, no `alloc_rsp_write_en`.
  - Response: exactly 2 grants, then none; one `alloc_rsp_write_en` pulse → exactly one more grant.
- Size mapping:
  - Stimulus: counts 0,1,2,4,5,8,9,15.
  - Response: (err,class) = (1,0),(0,0),(0,1),(0,2),(0,3),(0,3),(1,0),(1,0).
- Back-pressure:
  - Stimulus: `cmd_ready` low for 10 cycles in ISSUE.
  - Response: `cmd_valid` held with stable fields; no pop occurs during the stall.
- Enable and reset:
  - Drop `sched_en` in LOAD → the command still issues, then no further pops.
  - Assert `rst_n` low in ISSUE → the next cycle `cmd_valid`=0, counters=0, state is IDLE.
